// File: rtl/alu_adder_arbiter.sv
// Round-robin front end sharing one 4-bit adder among NUM_REQ requesters; one op in flight.
// Grant is issued in the cycle it is given, the result is valid two cycles later, and it is held until rsp_ready.

module alu_adder (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_sum
);
   logic [4:0] w_sum5;

   assign w_sum5 = {1'b0, i_a} + {1'b0, i_b};
   assign o_sum  = {3'b000, w_sum5};
endmodule

module alu_adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [7:0]           rsp_sum,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_win;
   logic [3:0]         r_a;
   logic [3:0]         r_b;
   logic [ID_W-1:0]    r_rsp_id;
   logic [7:0]         r_rsp_sum;
   logic               r_rsp_vld;
   logic [CNT_W-1:0]   r_op_count;

   logic [NUM_REQ-1:0] w_grant;
   logic               w_found;
   logic [ID_W-1:0]    w_win;
   logic [ID_W-1:0]    w_next_ptr;
   logic [3:0]         w_op_a;
   logic [3:0]         w_op_b;
   logic [NUM_REQ-1:0] w_req_ready;
   logic               w_fire;
   logic               w_rsp_fire;
   logic [7:0]         w_alu_sum;

   function automatic int wrap_idx(input int v);
      return (v >= NUM_REQ) ? v - NUM_REQ : v;
   endfunction

   // Search starts at r_rr_ptr; the operand mux rides along with the winner select.
   always_comb begin
      w_grant    = '0;
      w_found    = 1'b0;
      w_win      = '0;
      w_next_ptr = '0;
      w_op_a     = '0;
      w_op_b     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && (j == wrap_idx(int'(r_rr_ptr) + k)) && req_valid[j]) begin
               w_found    = 1'b1;
               w_grant[j] = 1'b1;
               w_win      = ID_W'(j);
               w_next_ptr = ID_W'(wrap_idx(j + 1));
               w_op_a     = req_a[4*j +: 4];
               w_op_b     = req_b[4*j +: 4];
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_req_ready = '0;
      w_fire      = 1'b0;
      w_rsp_fire  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!rst) begin
               w_req_ready = w_grant;
               if (w_found) begin
                  w_fire      = 1'b1;
                  w_state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC: w_state_nxt = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_fire  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   alu_adder u_alu (
      .i_a   (r_a),
      .i_b   (r_b),
      .o_sum (w_alu_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr   <= '0;
         r_win      <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_rsp_id   <= '0;
         r_rsp_sum  <= '0;
         r_rsp_vld  <= 1'b0;
         r_op_count <= '0;
      end else begin
         if (w_fire) begin
            r_a      <= w_op_a;
            r_b      <= w_op_b;
            r_win    <= w_win;
            r_rr_ptr <= w_next_ptr;
         end
         if (r_state == ST_CALC) begin
            r_rsp_sum <= w_alu_sum;
            r_rsp_id  <= r_win;
            r_rsp_vld <= 1'b1;
         end
         if (w_rsp_fire) begin
            r_rsp_vld  <= 1'b0;
            r_op_count <= r_op_count + CNT_W'(1);
         end
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = r_rsp_vld;
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_rsp_sum;
   assign busy      = (r_state != ST_IDLE);
   assign op_count  = r_op_count;
endmodule

// File: tb/tb_alu_adder_arbiter.sv
// Bench for alu_adder_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_adder_arbiter;
   localparam int N   = 4;
   localparam int IDW = 2;
   localparam int CW  = 8;
   localparam int AW  = 4 * N;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [AW-1:0]  req_a;
   logic [AW-1:0]  req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [7:0]     rsp_sum;
   logic           busy;
   logic [CW-1:0]  op_count;

   always #5 clk = ~clk;

   alu_adder_arbiter #(.NUM_REQ(N), .ID_W(IDW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .busy      (busy),
      .op_count  (op_count)
   );

   int n_vec  = 0;
   int n_miss = 0;

   // Model: an operation is "pending" from its grant until accepted; m_t counts edges since grant.
   bit m_busy  = 1'b0;
   int m_t     = 0;
   int m_ptr   = 0;
   int m_wid   = 0;
   int m_a     = 0;
   int m_b     = 0;
   int m_id    = 0;
   int m_sum   = 0;
   int m_count = 0;
   int fire_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic cycle(input bit r, input logic [N-1:0] v, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input bit rr);
      int w;
      logic [N-1:0] exp_rdy;
      rst       = r;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rr;
      @(negedge clk);
      w       = rr_pick(v, m_ptr);
      exp_rdy = '0;
      if (!r && !m_busy && w >= 0) exp_rdy = N'(1) << w;
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, (m_busy && m_t == 2));
      chk("busy", busy, m_busy);
      chk("op_count", op_count, m_count);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_sum", rsp_sum, m_sum);
      if (rsp_valid && rsp_ready) fire_q.push_back(int'(rsp_id));
      @(posedge clk);
      if (r) begin
         m_busy = 1'b0; m_t = 0; m_ptr = 0; m_id = 0; m_sum = 0; m_count = 0;
      end else if (!m_busy) begin
         if (w >= 0) begin
            m_busy = 1'b1;
            m_t    = 1;
            m_wid  = w;
            m_a    = int'(a >> (4 * w)) & 15;
            m_b    = int'(b >> (4 * w)) & 15;
            m_ptr  = (w + 1) % N;
         end
      end else if (m_t == 1) begin
         m_t   = 2;
         m_id  = m_wid;
         m_sum = m_a + m_b;
      end else if (rr) begin
         m_busy  = 1'b0;
         m_t     = 0;
         m_count = (m_count + 1) % (1 << CW);
      end
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_ops();
      return AW'($urandom);
   endfunction

   initial begin
      bit             r;
      logic [N-1:0]   v;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, '0, '0, '0, 1'b0);

      // Single op on requester 0: 3 + 4
      cycle(1'b0, 4'b0001, 16'h0003, 16'h0004, 1'b0);
      cycle(1'b0, 4'b0000, rnd_ops(), rnd_ops(), 1'b0);
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_id", rsp_id, 0);
      chk("t1_rsp_sum", rsp_sum, 8'd7);
      cycle(1'b0, 4'b0000, rnd_ops(), rnd_ops(), 1'b1);
      chk("t1_op_count", op_count, 1);

      // Max operands on requester 2
      cycle(1'b0, 4'b0100, 16'h0F00, 16'h0F00, 1'b0);
      cycle(1'b0, 4'b0000, rnd_ops(), rnd_ops(), 1'b0);
      chk("t2_rsp_sum", rsp_sum, 8'h1E);
      chk("t2_rsp_id", rsp_id, 2);
      cycle(1'b0, 4'b0000, rnd_ops(), rnd_ops(), 1'b1);

      // All requesters valid: four responses in twelve cycles, in order 0..3
      cycle(1'b1, '0, '0, '0, 1'b0);
      fire_q.delete();
      repeat (12) cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 1'b1);
      chk("t3_resp_count", fire_q.size(), 4);
      for (int i = 0; i < 4 && i < fire_q.size(); i++) chk("t3_order", fire_q[i], i);
      cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 1'b0);

      // Backpressure in RESP for five cycles
      cycle(1'b1, '0, '0, '0, 1'b0);
      cycle(1'b0, 4'b0010, 16'h00A0, 16'h0030, 1'b0);
      cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 1'b0);
      repeat (5) cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 1'b0);
      chk("t4_held_valid", rsp_valid, 1);
      chk("t4_held_sum", rsp_sum, 8'd13);
      cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 1'b1);
      cycle(1'b0, 4'b1111, rnd_ops(), rnd_ops(), 1'b0);

      // Reset during CALC aborts the op
      cycle(1'b1, '0, '0, '0, 1'b0);
      cycle(1'b0, 4'b0010, 16'h0090, 16'h0090, 1'b0);
      cycle(1'b1, 4'b0000, rnd_ops(), rnd_ops(), 1'b1);
      chk("t5_no_rsp", rsp_valid, 0);
      chk("t5_op_count", op_count, 0);
      cycle(1'b0, 4'b0011, rnd_ops(), rnd_ops(), 1'b1);
      repeat (3) cycle(1'b0, 4'b0000, rnd_ops(), rnd_ops(), 1'b1);

      // Operands changing right after the handshake
      cycle(1'b1, '0, '0, '0, 1'b0);
      cycle(1'b0, 4'b1000, 16'h5000, 16'h3000, 1'b0);
      cycle(1'b0, 4'b1000, 16'hC000, 16'h3000, 1'b0);
      chk("t6_sum_sampled", rsp_sum, 8'd8);
      cycle(1'b0, 4'b0000, rnd_ops(), rnd_ops(), 1'b1);

      // Random traffic; the long reset-free tail wraps op_count
      for (int i = 0; i < 4000; i++) begin
         r = (i < 1500) && ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         cycle(r, v, rnd_ops(), rnd_ops(), ($urandom_range(0, 4) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
